// File: rtl/aes_round_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : aes_round_ctrl_if
//  Description : Handshake and round-control bundle between the block-level
//                front end (master) and the AES round sequencer (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface aes_round_ctrl_if;
    logic       start;
    logic       start_ready;
    logic       key_valid;
    logic       key_req;
    logic [3:0] round_out;
    logic       ark_en;
    logic       sb_en;
    logic       sr_en;
    logic       mc_en;
    logic       state_we;
    logic       busy;
    logic       done;

    // Front end: issues start, supplies key availability, observes control.
    modport master (
        output start, key_valid,
        input  start_ready, key_req, round_out, ark_en, sb_en, sr_en,
               mc_en, state_we, busy, done
    );

    // Sequencer: consumes start/key_valid, drives all control outputs.
    modport slave (
        input  start, key_valid,
        output start_ready, key_req, round_out, ark_en, sb_en, sr_en,
               mc_en, state_we, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/aes_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : aes_round_ctrl
//  Description : AES round sequencer. Walks INIT (round 0), ROUND (1..NR-1),
//                FINAL (NR) and DONE, driving round index, stage enables and
//                the state-register write strobe.
//                Optional macro AES_CTRL_KEY_WAIT_EN: stall each working
//                cycle until key_valid is high.
//  Revision    : 1.0  initial release
// ============================================================================
module aes_round_ctrl #(
    parameter int NR = 10               // 10, 12 or 14
) (
    input  wire              clk,
    input  wire              rst_n,
    aes_round_ctrl_if.slave  bus
);

    localparam logic [3:0] ROUND_LAST = 4'(NR);
    localparam logic [3:0] ROUND_PEN  = 4'(NR - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_ROUND = 3'd2,
        S_FINAL = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] round, round_nxt;
    logic       advance;
    logic       key_wait;

    logic start_ready, key_req, ark_en, sb_en, sr_en, mc_en, state_we, busy, done;

`ifdef AES_CTRL_KEY_WAIT_EN
    // Working cycles only progress once the round key is on the bus.
    assign advance  = bus.key_valid;
    assign key_wait = 1'b1;
`else
    // Key is assumed always ready; key_valid is intentionally ignored.
    logic unused_key_valid;
    assign unused_key_valid = bus.key_valid;
    assign advance  = 1'b1;
    assign key_wait = 1'b0;
`endif

    // State and round counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            round <= 4'd0;
        end else begin
            state <= state_nxt;
            round <= round_nxt;
        end
    end

    // Next-state, round counter update and output decode.
    always_comb begin
        state_nxt   = state;
        round_nxt   = round;
        start_ready = 1'b0;
        key_req     = 1'b0;
        ark_en      = 1'b0;
        sb_en       = 1'b0;
        sr_en       = 1'b0;
        mc_en       = 1'b0;
        state_we    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            S_IDLE: begin
                start_ready = 1'b1;
                if (bus.start) begin
                    state_nxt = S_INIT;
                    round_nxt = 4'd0;
                end
            end
            S_INIT: begin
                busy     = 1'b1;
                key_req  = key_wait;
                ark_en   = advance;
                state_we = advance;
                if (advance) begin
                    state_nxt = S_ROUND;
                    round_nxt = 4'd1;
                end
            end
            S_ROUND: begin
                busy     = 1'b1;
                key_req  = key_wait;
                ark_en   = advance;
                sb_en    = advance;
                sr_en    = advance;
                mc_en    = advance;
                state_we = advance;
                if (advance) begin
                    if (round == ROUND_PEN) begin
                        state_nxt = S_FINAL;
                        round_nxt = ROUND_LAST;
                    end else begin
                        round_nxt = round + 4'd1;
                    end
                end
            end
            S_FINAL: begin
                // Last AES round skips mix-columns.
                busy     = 1'b1;
                key_req  = key_wait;
                ark_en   = advance;
                sb_en    = advance;
                sr_en    = advance;
                state_we = advance;
                if (advance) state_nxt = S_DONE;
            end
            S_DONE: begin
                // round_out still shows NR here; cleared on return to IDLE.
                done      = 1'b1;
                state_nxt = S_IDLE;
                round_nxt = 4'd0;
            end
            default: begin
                state_nxt = S_IDLE;
                round_nxt = 4'd0;
            end
        endcase
    end

    assign bus.start_ready = start_ready;
    assign bus.key_req     = key_req;
    assign bus.round_out   = round;
    assign bus.ark_en      = ark_en;
    assign bus.sb_en       = sb_en;
    assign bus.sr_en       = sr_en;
    assign bus.mc_en       = mc_en;
    assign bus.state_we    = state_we;
    assign bus.busy        = busy;
    assign bus.done        = done;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_round_ctrl
//  Description : Self-checking bench for aes_round_ctrl. Two instances
//                (NR=10 and NR=14) share stimulus; each is compared every
//                cycle against a step-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_aes_round_ctrl;

`ifdef AES_CTRL_KEY_WAIT_EN
    localparam bit WAIT = 1'b1;
`else
    localparam bit WAIT = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    aes_round_ctrl_if bus10();
    aes_round_ctrl_if bus14();

    aes_round_ctrl #(.NR(10)) dut10 (.clk(clk), .rst_n(rst_n), .bus(bus10));
    aes_round_ctrl #(.NR(14)) dut14 (.clk(clk), .rst_n(rst_n), .bus(bus14));

    always #5 clk = ~clk;

    // Free-running cycle counter used for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    // Packed view of all outputs:
    // {start_ready, key_req, round_out[3:0], ark, sb, sr, mc, state_we, busy, done}
    logic [12:0] obs0, obs1;
    assign obs0 = {bus10.start_ready, bus10.key_req, bus10.round_out, bus10.ark_en,
                   bus10.sb_en, bus10.sr_en, bus10.mc_en, bus10.state_we,
                   bus10.busy, bus10.done};
    assign obs1 = {bus14.start_ready, bus14.key_req, bus14.round_out, bus14.ark_en,
                   bus14.sb_en, bus14.sr_en, bus14.mc_en, bus14.state_we,
                   bus14.busy, bus14.done};

    // Model: step -1 = idle, 0 = round 0, k = round k (k<=nr), nr+1 = done cycle.
    int nr_of [2] = '{10, 14};
    int step  [2];
    int acc   [2];
    int stl   [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [12:0] exp_vec(input int nr, input int s, input bit kv);
        logic [12:0] v;
        bit go;
        v  = '0;
        go = WAIT ? kv : 1'b1;
        if (s < 0) begin
            v[12] = 1'b1;
        end else if (s <= nr) begin
            v[11]   = WAIT;
            v[10:7] = 4'(s);
            v[6]    = go;
            v[5]    = go && (s >= 1);
            v[4]    = go && (s >= 1);
            v[3]    = go && (s >= 1) && (s < nr);
            v[2]    = go;
            v[1]    = 1'b1;
        end else begin
            v[10:7] = 4'(nr);
            v[0]    = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [12:0] get_obs(input int i);
        return (i == 0) ? obs0 : obs1;
    endfunction

    task automatic drive(input bit s, input bit kv);
        bus10.start = s;  bus10.key_valid = kv;
        bus14.start = s;  bus14.key_valid = kv;
    endtask

    // One clock: apply inputs, check outputs against the model, advance model.
    task automatic tick(input bit s, input bit kv);
        bit go;
        @(negedge clk);
        drive(s, kv);
        #1;
        go = WAIT ? kv : 1'b1;
        for (int i = 0; i < 2; i++) begin
            check((i == 0) ? "outs_nr10" : "outs_nr14", 32'(get_obs(i)),
                  32'(exp_vec(nr_of[i], step[i], kv)));
            if (step[i] == nr_of[i] + 1)
                check((i == 0) ? "latency_nr10" : "latency_nr14",
                      32'(cyc - acc[i]), 32'(nr_of[i] + 2 + stl[i]));
            if (step[i] < 0) begin
                if (s) begin
                    step[i] = 0;
                    acc[i]  = cyc;
                    stl[i]  = 0;
                end
            end else if (step[i] <= nr_of[i]) begin
                if (go) step[i]++;
                else    stl[i]++;
            end else begin
                step[i] = -1;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int stalled;
        drive(1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step[i] = -1; acc[i] = 0; stl[i] = 0;
        end

        // Reset state.
        repeat (3) begin
            @(negedge clk); #1;
            check("reset_nr10", 32'(obs0), 32'(exp_vec(10, -1, 1'b0)));
            check("reset_nr14", 32'(obs1), 32'(exp_vec(14, -1, 1'b0)));
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Single start pulse, no stalls.
        tick(1'b1, 1'b1);
        repeat (20) tick(1'b0, 1'b1);

        // Single start pulse with key_valid low throughout.
        tick(1'b1, 1'b0);
        repeat (20) tick(1'b0, 1'b0);

        // start held high: back-to-back blocks, no early acceptance.
        repeat (40) tick(1'b1, 1'b1);
        repeat (20) tick(1'b0, 1'b1);

        // Drop key_valid for three cycles while at round 5.
        stalled = 0;
        tick(1'b1, 1'b1);
        repeat (25) begin
            if (step[0] == 5 && stalled < 3) begin
                stalled++;
                tick(1'b0, 1'b0);
            end else begin
                tick(1'b0, 1'b1);
            end
        end

        // Randomized start and key availability.
        repeat (400) tick($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
        repeat (25) tick(1'b0, 1'b1);

        // Asynchronous reset mid-operation at round 7.
        tick(1'b1, 1'b1);
        for (int k = 0; k < 40; k++) begin
            if (step[0] == 7) break;
            tick(1'b0, 1'b1);
        end
        @(posedge clk); #2;
        check("reach_r7", 32'(bus10.round_out), 32'd7);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) step[i] = -1;
        check("async_rst_nr10", 32'(obs0), 32'(exp_vec(10, -1, 1'b1)));
        check("async_rst_nr14", 32'(obs1), 32'(exp_vec(14, -1, 1'b1)));
        @(negedge clk); #1;
        check("hold_rst_nr10", 32'(obs0), 32'(exp_vec(10, -1, 1'b1)));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) tick(1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
